// File: rtl/cam_pkg.sv
// Shared types and default constants for the camera capture front end.
package cam_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_VS,
        CAPTURE,
        DONE
    } cam_state_t;

    localparam int unsigned H_PIX_DEFAULT    = 640;
    localparam int unsigned V_LINES_DEFAULT  = 480;
    localparam int unsigned DEC_LOG2_DEFAULT = 2;
    localparam int unsigned ADDR_W_DEFAULT   = 15;
    localparam int unsigned RGB444_W         = 12;

endpackage

// File: rtl/cam_sync.sv
// Two-flop synchronizer with a history flop, giving level plus rise/fall events.
module cam_sync #(
    parameter int unsigned W = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] din,
    output logic [W-1:0] level,
    output logic [W-1:0] rise,
    output logic [W-1:0] fall
);

    logic [W-1:0] meta;
    logic [W-1:0] sync;
    logic [W-1:0] hist;

    always_ff @(posedge clk) begin
        if (!rst) begin
            meta <= '0;
            sync <= '0;
            hist <= '0;
        end else begin
            meta <= din;
            sync <= meta;
            hist <= sync;
        end
    end

    assign level = sync;
    assign rise  = sync & ~hist;
    assign fall  = ~sync & hist;

endmodule

// File: rtl/cam_capture.sv
// Camera frame capture: synchronizes the OV-style bus, decimates, and emits
// one linear frame-buffer write per kept pixel for each requested frame.
module cam_capture
    import cam_pkg::*;
#(
    parameter int unsigned H_PIX    = H_PIX_DEFAULT,
    parameter int unsigned V_LINES  = V_LINES_DEFAULT,
    parameter int unsigned DEC_LOG2 = DEC_LOG2_DEFAULT,
    parameter int unsigned ADDR_W   = ADDR_W_DEFAULT
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    output logic                busy,
    output logic                done,
    output logic                err,
    input  logic                cam_vsync,
    input  logic                cam_href,
    input  logic                cam_pclk,
    input  logic [RGB444_W-1:0] cam_data,
    output logic                wr_en,
    output logic [ADDR_W-1:0]   wr_addr,
    output logic [RGB444_W-1:0] wr_data
);

    localparam int unsigned COL_W = $clog2(H_PIX + 1);
    localparam int unsigned ROW_W = $clog2(V_LINES + 1);
    localparam logic [COL_W-1:0] COL_END  = COL_W'(H_PIX);
    localparam logic [ROW_W-1:0] ROW_END  = ROW_W'(V_LINES);
    localparam logic [COL_W-1:0] COL_MASK = COL_W'((1 << DEC_LOG2) - 1);
    localparam logic [ROW_W-1:0] ROW_MASK = ROW_W'((1 << DEC_LOG2) - 1);

    cam_state_t state, state_next;

    logic [2:0]          ctl_level, ctl_rise, ctl_fall;
    logic [RGB444_W-1:0] data_meta, data_sync;
    logic                pclk_rise, href_lvl, href_fall, vs_rise, vs_fall;
    logic                sync_unused;

    logic [COL_W-1:0]    col, col_pix;
    logic [ROW_W-1:0]    row, row_line;
    logic [ADDR_W-1:0]   addr;
    logic                addr_full;
    logic                pix_valid, pix_keep;

    cam_sync #(
        .W (3)
    ) u_sync (
        .clk   (clk),
        .rst   (rst),
        .din   ({cam_vsync, cam_href, cam_pclk}),
        .level (ctl_level),
        .rise  (ctl_rise),
        .fall  (ctl_fall)
    );

    assign pclk_rise   = ctl_rise[0];
    assign href_lvl    = ctl_level[1];
    assign href_fall   = ctl_fall[1];
    assign vs_rise     = ctl_rise[2];
    assign vs_fall     = ctl_fall[2];
    assign sync_unused = ^{ctl_level[2], ctl_level[0], ctl_rise[1], ctl_fall[0]};

    // A pixel whose pclk rise coincides with href falling still belongs to the line.
    assign pix_valid = pclk_rise & (href_lvl | href_fall);
    assign pix_keep  = ((col & COL_MASK) == '0) && ((row & ROW_MASK) == '0);
    assign col_pix   = (pix_valid && (col != '1)) ? col + COL_W'(1) : col;
    assign row_line  = (href_fall && (row != '1)) ? row + ROW_W'(1) : row;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start)   state_next = WAIT_VS;
            WAIT_VS: if (vs_fall) state_next = CAPTURE;
            CAPTURE: if (vs_rise) state_next = DONE;
            DONE:                 state_next = IDLE;
            default:              state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            data_meta <= '0;
            data_sync <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            wr_en     <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
            col       <= '0;
            row       <= '0;
            addr      <= '0;
            addr_full <= 1'b0;
        end else begin
            data_meta <= cam_data;
            data_sync <= data_meta;
            wr_en     <= 1'b0;
            done      <= (state == DONE);
            // Kept high through the done pulse so busy and done drop together.
            busy      <= (state_next != IDLE) || (state == DONE);
            case (state)
                IDLE: begin
                    if (start) err <= 1'b0;
                end
                WAIT_VS: begin
                    if (vs_fall) begin
                        col       <= '0;
                        row       <= '0;
                        addr      <= '0;
                        addr_full <= 1'b0;
                    end
                end
                CAPTURE: begin
                    if (pix_valid && pix_keep) begin
                        if (addr_full) begin
                            err <= 1'b1;
                        end else begin
                            wr_en     <= 1'b1;
                            wr_addr   <= addr;
                            wr_data   <= data_sync;
                            addr      <= addr + ADDR_W'(1);
                            addr_full <= (addr == '1);
                        end
                    end
                    // Line end is judged on the column count including a same-cycle pixel.
                    if (href_fall) begin
                        if (col_pix != COL_END) err <= 1'b1;
                        col <= '0;
                        row <= row_line;
                    end else begin
                        col <= col_pix;
                    end
                    if (vs_rise && (row_line != ROW_END)) err <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cam_capture.sv
// Scoreboard bench for cam_capture on a reduced 16x12 frame with 4x decimation.
module tb_cam_capture;

    localparam int unsigned H    = 16;
    localparam int unsigned V    = 12;
    localparam int unsigned DL   = 2;
    localparam int unsigned AW   = 4;
    localparam int unsigned DEC  = 1 << DL;
    localparam int unsigned KEPT = (H / DEC) * (V / DEC);

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          busy, done, err;
    logic          cam_vsync, cam_href, cam_pclk;
    logic [11:0]   cam_data;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [11:0]   wr_data;

    always #5 clk = ~clk;

    cam_capture #(
        .H_PIX    (H),
        .V_LINES  (V),
        .DEC_LOG2 (DL),
        .ADDR_W   (AW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .cam_vsync (cam_vsync),
        .cam_href  (cam_href),
        .cam_pclk  (cam_pclk),
        .cam_data  (cam_data),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data)
    );

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [11:0]   data;
    } wr_t;

    wr_t sb[$];
    int  exp_addr;
    int  n_wr;
    int  n_checks;
    int  n_fail;

    always @(negedge clk) begin : monitor
        wr_t e;
        if (rst && wr_en) begin
            n_wr++;
            n_checks++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL write_unexpected: got addr %0d data %0d, required no write", wr_addr, wr_data);
            end else begin
                e = sb.pop_front();
                if (wr_addr !== e.addr || wr_data !== e.data) begin
                    n_fail++;
                    $display("FAIL write_content: got addr %0d data %0d, required addr %0d data %0d",
                             wr_addr, wr_data, e.addr, e.data);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    task automatic issue_start();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    task automatic lat_check();
        @(posedge clk); #1;
        n_checks++;
        if (wr_en !== 1'b0) begin
            n_fail++; $display("FAIL wr_en_lat_e0: wr_en=%b, required 0", wr_en);
        end
        @(posedge clk); #1;
        n_checks++;
        if (wr_en !== 1'b0) begin
            n_fail++; $display("FAIL wr_en_lat_e1: wr_en=%b, required 0", wr_en);
        end
        @(posedge clk); #1;
        n_checks++;
        if (wr_en !== 1'b1 || wr_addr !== '0 || wr_data !== 12'd0) begin
            n_fail++;
            $display("FAIL wr_en_lat_e2: wr_en=%b addr=%0d data=%0d, required 1/0/0", wr_en, wr_addr, wr_data);
        end
    endtask

    task automatic frame_begin();
        @(negedge clk) cam_vsync = 1'b1;
        repeat (6) @(negedge clk);
        cam_vsync = 1'b0;
        exp_addr  = 0;
        repeat (8) @(negedge clk);
    endtask

    // pclk period is exactly 4 clk cycles; href falls with pclk unless coinc.
    task automatic drive_line(input int r, input int npix, input bit coinc,
                              input bit expect_wr, input bit lat);
        for (int c = 0; c < npix; c++) begin
            @(negedge clk);
            cam_pclk = 1'b0;
            cam_href = 1'b1;
            cam_data = 12'(r * H + c);
            @(negedge clk);
            @(negedge clk);
            cam_pclk = 1'b1;
            if (coinc && c == npix - 1) cam_href = 1'b0;
            if (expect_wr && (r % DEC) == 0 && (c % DEC) == 0) begin
                sb.push_back(wr_t'{addr: AW'(exp_addr), data: 12'(r * H + c)});
                exp_addr++;
            end
            if (lat && c == 0) fork lat_check(); join_none
            @(negedge clk);
        end
        @(negedge clk);
        cam_pclk = 1'b0;
        cam_href = 1'b0;
        repeat (8) @(negedge clk);
    endtask

    task automatic frame_end(input bit exp_err, input string tag);
        bit early;
        early = 1'b0;
        @(negedge clk) cam_vsync = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
            if (done !== 1'b0) early = 1'b1;
        end
        n_checks++;
        if (early) begin
            n_fail++; $display("FAIL %s_done_early: done seen before 4th edge, required 0", tag);
        end
        @(posedge clk); #1;
        n_checks++;
        if (done !== 1'b1 || busy !== 1'b1) begin
            n_fail++; $display("FAIL %s_done_pulse: done=%b busy=%b, required 1/1", tag, done, busy);
        end
        n_checks++;
        if (err !== exp_err) begin
            n_fail++; $display("FAIL %s_err: err=%b, required %b", tag, err, exp_err);
        end
        @(posedge clk); #1;
        n_checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            n_fail++; $display("FAIL %s_done_end: done=%b busy=%b, required 0/0", tag, done, busy);
        end
        repeat (4) @(negedge clk);
        n_checks++;
        if (sb.size() != 0 || n_wr != KEPT) begin
            n_fail++;
            $display("FAIL %s_writes: writes=%0d pending=%0d, required %0d/0", tag, n_wr, sb.size(), KEPT);
        end
    endtask

    task automatic frame_end_quiet(input string tag);
        bit bad;
        bad = 1'b0;
        @(negedge clk) cam_vsync = 1'b1;
        repeat (8) begin
            @(posedge clk); #1;
            if (done !== 1'b0 || busy !== 1'b1) bad = 1'b1;
        end
        n_checks++;
        if (bad || n_wr != 0) begin
            n_fail++;
            $display("FAIL %s_ignored_frame: bad=%b writes=%0d, required busy held, no done, 0 writes", tag, bad, n_wr);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++; if (busy !== 1'b0)  begin n_fail++; $display("FAIL reset_busy: %b, required 0", busy); end
        n_checks++; if (done !== 1'b0)  begin n_fail++; $display("FAIL reset_done: %b, required 0", done); end
        n_checks++; if (err !== 1'b0)   begin n_fail++; $display("FAIL reset_err: %b, required 0", err); end
        n_checks++; if (wr_en !== 1'b0) begin n_fail++; $display("FAIL reset_wr_en: %b, required 0", wr_en); end
        n_checks++; if (wr_addr !== '0) begin n_fail++; $display("FAIL reset_wr_addr: %0d, required 0", wr_addr); end
        n_checks++; if (wr_data !== '0) begin n_fail++; $display("FAIL reset_wr_data: %0d, required 0", wr_data); end
        rst = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_full_frame();
        n_wr = 0;
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL full_busy_idle: %b, required 0", busy); end
        start = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if (busy !== 1'b1) begin n_fail++; $display("FAIL full_busy_rise: %b, required 1", busy); end
        @(negedge clk) start = 1'b0;
        frame_begin();
        for (int r = 0; r < V; r++) drive_line(r, H, 1'b0, 1'b1, r == 0);
        frame_end(1'b0, "full");
    endtask

    task automatic test_short_line();
        n_wr = 0;
        issue_start();
        frame_begin();
        for (int r = 0; r < V; r++) drive_line(r, (r == 5) ? H - 1 : H, 1'b0, 1'b1, 1'b0);
        frame_end(1'b1, "short_line");
    endtask

    task automatic test_short_frame();
        n_wr = 0;
        issue_start();
        n_checks++;
        if (err !== 1'b0 || busy !== 1'b1) begin
            n_fail++; $display("FAIL start_clears_err: err=%b busy=%b, required 0/1", err, busy);
        end
        frame_begin();
        for (int r = 0; r < V - 1; r++) begin
            drive_line(r, H, 1'b0, 1'b1, 1'b0);
            if (r == 3) begin
                issue_start();
                n_checks++;
                if (busy !== 1'b1) begin n_fail++; $display("FAIL start_in_capture: busy=%b, required 1", busy); end
            end
        end
        frame_end(1'b1, "short_frame");
    endtask

    task automatic test_coincident();
        n_wr = 0;
        issue_start();
        frame_begin();
        for (int r = 0; r < V; r++) drive_line(r, H, 1'b1, 1'b1, 1'b0);
        frame_end(1'b0, "coincident");
    endtask

    task automatic test_start_mid_frame();
        n_wr = 0;
        @(negedge clk) cam_vsync = 1'b1;
        repeat (6) @(negedge clk);
        cam_vsync = 1'b0;
        for (int r = 0; r < 4; r++) drive_line(r, H, 1'b0, 1'b0, 1'b0);
        issue_start();
        for (int r = 4; r < V; r++) drive_line(r, H, 1'b0, 1'b0, 1'b0);
        frame_end_quiet("mid_start");
        frame_begin();
        for (int r = 0; r < V; r++) drive_line(r, H, 1'b0, 1'b1, 1'b0);
        frame_end(1'b0, "mid_start");
    endtask

    task automatic test_reset_mid_capture();
        n_wr = 0;
        issue_start();
        frame_begin();
        for (int r = 0; r < 3; r++) drive_line(r, H, 1'b0, 1'b1, 1'b0);
        n_checks++;
        if (busy !== 1'b1 || n_wr != H / DEC) begin
            n_fail++; $display("FAIL rst_mid_pre: busy=%b writes=%0d, required 1/%0d", busy, n_wr, H / DEC);
        end
        @(negedge clk) rst = 1'b0;
        @(posedge clk); #1;
        n_checks++;
        if ({busy, done, err, wr_en} !== 4'b0000 || wr_addr !== '0 || wr_data !== '0) begin
            n_fail++;
            $display("FAIL rst_mid_outputs: busy=%b done=%b err=%b wr_en=%b addr=%0d data=%0d, required all 0",
                     busy, done, err, wr_en, wr_addr, wr_data);
        end
        @(negedge clk) rst = 1'b1;
        n_wr = 0;
        issue_start();
        for (int r = 3; r < V; r++) drive_line(r, H, 1'b0, 1'b0, 1'b0);
        frame_end_quiet("rst_mid");
        frame_begin();
        for (int r = 0; r < V; r++) drive_line(r, H, 1'b0, 1'b1, 1'b0);
        frame_end(1'b0, "rst_mid");
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        n_wr      = 0;
        exp_addr  = 0;
        start     = 1'b0;
        cam_vsync = 1'b1;
        cam_href  = 1'b0;
        cam_pclk  = 1'b0;
        cam_data  = '0;
        test_reset();
        test_full_frame();
        test_short_line();
        test_short_frame();
        test_coincident();
        test_start_mid_frame();
        test_reset_mid_capture();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
